lane_frame_gen: RTL



---
 rtl/lane_frame_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lane_frame_gen.sv
// Multi-lane transmit traffic source: K28.5 idle beats, then bursts of
// SOF / incrementing payload / EOF frames separated by an idle gap.
module lane_frame_gen #(
    parameter int LANS  = 4,
    parameter int BYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       start,
    input  logic [15:0]                pkt_len,
    input  logic [15:0]                pkt_num,
    input  logic [7:0]                 ipg,
    input  logic                       ready,
    output logic [LANS*BYTES*8-1:0]    tdat,
    output logic [LANS*BYTES-1:0]      tdatk,
    output logic [LANS-1:0]            tdatv,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                frame_cnt
);

    localparam int NB = LANS * BYTES;

    typedef enum logic [2:0] {S_OFF, S_IDLE, S_SOF, S_PAY, S_EOF, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [15:0]       pay_idx_q, pay_idx_d;
    logic [7:0]        gap_q, gap_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       num_q, num_d;
    logic [7:0]        ipg_q, ipg_d;
    logic [NB*8-1:0]   tdat_q, tdat_d;
    logic [NB-1:0]     tdatk_q, tdatk_d;
    logic [LANS-1:0]   tdatv_q, tdatv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              advance;
    logic              enter_eof;
    logic [15:0]       eof_cnt;
    logic [7:0]        pay_base;

    // state_q always names the beat currently on the output; the next beat
    // is chosen and encoded here, and only loaded when the output may move.
    always_comb begin
        state_d     = state_q;
        pay_idx_d   = pay_idx_q;
        gap_d       = gap_q;
        len_d       = len_q;
        num_d       = num_q;
        ipg_d       = ipg_q;
        busy_d      = busy_q;
        done_d      = done_q;
        frame_cnt_d = frame_cnt_q;
        enter_eof   = 1'b0;
        advance     = ready || !tdatv_q[0];
        eof_cnt     = frame_cnt_q + 16'd1;

        if (!en) begin
            state_d = S_OFF;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else if (advance) begin
            done_d = 1'b0;
            unique case (state_q)
                S_OFF: state_d = S_IDLE;
                S_IDLE: begin
                    if (start) begin
                        frame_cnt_d = '0;
                        if (pkt_num != 16'd0) begin
                            len_d     = pkt_len;
                            num_d     = pkt_num;
                            ipg_d     = ipg;
                            busy_d    = 1'b1;
                            pay_idx_d = '0;
                            state_d   = S_SOF;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_SOF: begin
                    pay_idx_d = '0;
                    if (len_q == 16'd0) enter_eof = 1'b1;
                    else                state_d   = S_PAY;
                end
                S_PAY: begin
                    if (pay_idx_q + 16'd1 == len_q) enter_eof = 1'b1;
                    else                            pay_idx_d = pay_idx_q + 16'd1;
                end
                S_EOF: begin
                    if (frame_cnt_q == num_q) begin
                        state_d = S_IDLE;
                    end else if (ipg_q == 8'd0) begin
                        state_d   = S_SOF;
                        pay_idx_d = '0;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_q == ipg_q) begin
                        state_d   = S_SOF;
                        pay_idx_d = '0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                default: state_d = S_OFF;
            endcase

            // Busy drops and done pulses together with the final EOF beat.
            if (enter_eof) begin
                state_d     = S_EOF;
                frame_cnt_d = eof_cnt;
                if (eof_cnt == num_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end

        tdat_d   = '0;
        tdatk_d  = '0;
        tdatv_d  = (state_d == S_OFF) ? '0 : '1;
        pay_base = 8'(pay_idx_d * 16'(NB));
        case (state_d)
            S_IDLE, S_GAP: begin
                tdat_d  = {NB{8'hBC}};
                tdatk_d = '1;
            end
            S_SOF, S_EOF: begin
                for (int l = 0; l < LANS; l++) begin
                    tdat_d[l*BYTES*8 +: 8] = (state_d == S_SOF) ? 8'hFB : 8'hFD;
                    tdatk_d[l*BYTES]       = 1'b1;
                end
            end
            S_PAY: begin
                for (int i = 0; i < NB; i++) begin
                    tdat_d[i*8 +: 8] = pay_base + 8'(i);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            pay_idx_q   <= '0;
            gap_q       <= '0;
            len_q       <= '0;
            num_q       <= '0;
            ipg_q       <= '0;
            tdat_q      <= '0;
            tdatk_q     <= '0;
            tdatv_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pay_idx_q   <= pay_idx_d;
            gap_q       <= gap_d;
            len_q       <= len_d;
            num_q       <= num_d;
            ipg_q       <= ipg_d;
            tdat_q      <= tdat_d;
            tdatk_q     <= tdatk_d;
            tdatv_q     <= tdatv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tdat      = tdat_q;
    assign tdatk     = tdatk_q;
    assign tdatv     = tdatv_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

endmodule
